// File: rtl/reaction_timer_core.sv
// Reaction-time tester core: random hold-off delay, go-lamp, per-player ms timing,
// early-press foul detection, lowest-index arbitration and slow-round timeout.
module reaction_timer_core #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned N_PLAYERS    = 2,
  parameter int unsigned MIN_DELAY_MS = 2000,
  parameter int unsigned SPAN_LOG2    = 12,
  parameter int unsigned MS_W         = 14,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk_50M,
  input  logic                 clear,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] stop,
  output logic                 led,
  output logic [2:0]           state,
  output logic [MS_W-1:0]      react_ms,
  output logic [2:0]           winner,
  output logic [N_PLAYERS-1:0] foul,
  output logic                 done
);

  localparam int unsigned PRESC_DIV = CLK_HZ / 1000;
  localparam int unsigned PRESC_W   = $clog2(PRESC_DIV);
  localparam int unsigned DLY_W     = $clog2(MIN_DELAY_MS + (1 << SPAN_LOG2));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ARMED   = 3'd2,
    S_DONE    = 3'd3,
    S_FOUL    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t               fsm;
  logic                 start_q;
  logic [N_PLAYERS-1:0] stop_q;
  logic                 start_rise;
  logic [N_PLAYERS-1:0] stop_rise;
  logic                 any_stop;
  logic [15:0]          lfsr;
  logic                 lfsr_fb;
  logic [PRESC_W-1:0]   presc;
  logic                 tick;
  logic [DLY_W-1:0]     dly_cnt;
  logic [DLY_W-1:0]     dly_next;
  logic [DLY_W-1:0]     dly_target;
  logic [DLY_W-1:0]     next_target;
  logic [2:0]           first_idx;
  logic                 idle_like;
  logic                 round_go;
  logic                 wait_tick;
  logic                 wait_foul;
  logic                 wait_expire;
  logic                 armed_stop;
  logic                 armed_tick;
  logic                 armed_timeout;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  assign any_stop   = |stop_rise;

  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick        = (presc == PRESC_W'(PRESC_DIV - 1));
  assign dly_next    = dly_cnt + DLY_W'(1);
  assign next_target = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[SPAN_LOG2-1:0]);

  // Round events; a stop rise always outranks the same-cycle tick.
  assign idle_like     = (fsm == S_IDLE) || (fsm == S_DONE) ||
                         (fsm == S_FOUL) || (fsm == S_TIMEOUT);
  assign round_go      = idle_like && start_rise;
  assign wait_foul     = (fsm == S_WAIT) && any_stop;
  assign wait_tick     = (fsm == S_WAIT) && !any_stop && tick;
  assign wait_expire   = wait_tick && (dly_next == dly_target);
  assign armed_stop    = (fsm == S_ARMED) && any_stop;
  assign armed_tick    = (fsm == S_ARMED) && !any_stop && tick;
  assign armed_timeout = armed_tick && (react_ms == MS_W'(TIMEOUT_MS));

  // Lowest-index player among simultaneous rises wins.
  always_comb begin
    first_idx = 3'd0;
    for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
      if (stop_rise[i]) first_idx = 3'(i);
    end
  end

  // Edge history starts high so buttons held through reset stay silent.
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      start_q <= 1'b1;
      stop_q  <= '1;
    end else begin
      start_q <= start;
      stop_q  <= stop;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (clear) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // ms timebase, realigned whenever a timed phase begins.
  always_ff @(posedge clk_50M) begin
    if (clear || round_go || wait_expire || tick) presc <= '0;
    else                                          presc <= presc + PRESC_W'(1);
  end

  always_ff @(posedge clk_50M) begin
    if (clear) begin
      dly_cnt    <= '0;
      dly_target <= '0;
    end else if (round_go) begin
      dly_cnt    <= '0;
      dly_target <= next_target;
    end else if (wait_tick) begin
      dly_cnt    <= dly_next;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (clear) begin
      fsm      <= S_IDLE;
      led      <= 1'b0;
      react_ms <= '0;
      winner   <= 3'd0;
      foul     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (fsm)
        S_IDLE, S_DONE, S_FOUL, S_TIMEOUT: begin
          if (round_go) begin
            fsm      <= S_WAIT;
            react_ms <= '0;
            winner   <= 3'd0;
            foul     <= '0;
          end
        end
        S_WAIT: begin
          if (wait_foul) begin
            fsm  <= S_FOUL;
            foul <= stop_rise;
            done <= 1'b1;
          end else if (wait_expire) begin
            fsm <= S_ARMED;
            led <= 1'b1;
          end
        end
        S_ARMED: begin
          if (armed_stop) begin
            fsm    <= S_DONE;
            led    <= 1'b0;
            winner <= first_idx;
            done   <= 1'b1;
          end else if (armed_timeout) begin
            fsm  <= S_TIMEOUT;
            led  <= 1'b0;
            done <= 1'b1;
          end else if (armed_tick) begin
            react_ms <= react_ms + MS_W'(1);
          end
        end
        default: begin
          fsm <= S_IDLE;
          led <= 1'b0;
        end
      endcase
    end
  end

  assign state = fsm;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: a short vector table for reset and
// early-press paths, then hand-timed rounds for arming, stops, timeout and clear.
module tb_reaction_timer_core;

  localparam int unsigned N    = 3;
  localparam int unsigned MSW  = 14;
  localparam int          MIND = 5;
  localparam int          TMO  = 20;

  logic           clk_50M = 1'b0;
  logic           clear;
  logic           start;
  logic [N-1:0]   stop;
  logic           led;
  logic [2:0]     state;
  logic [MSW-1:0] react_ms;
  logic [2:0]     winner;
  logic [N-1:0]   foul;
  logic           done;

  always #5 clk_50M = ~clk_50M;

  reaction_timer_core #(
    .CLK_HZ(4000),
    .N_PLAYERS(N),
    .MIN_DELAY_MS(MIND),
    .SPAN_LOG2(3),
    .MS_W(MSW),
    .TIMEOUT_MS(TMO),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_50M(clk_50M),
    .clear(clear),
    .start(start),
    .stop(stop),
    .led(led),
    .state(state),
    .react_ms(react_ms),
    .winner(winner),
    .foul(foul),
    .done(done)
  );

  int checks   = 0;
  int failures = 0;
  int n_adv    = 0;
  int since    = 0;
  int delays[$];

  // Edges since the last clear edge: how far the LFSR has stepped from its seed.
  always @(posedge clk_50M) n_adv <= clear ? 0 : n_adv + 1;

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[14:0], ^(l & 16'hB400)};
    return l;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_50M);
      since++;
    end
  endtask

  task automatic begin_round(input string tag, output int t);
    logic [15:0] l;
    step(1);
    l = lfsr_at(n_adv);
    t = MIND + int'(l[2:0]);
    start = 1'b1;
    since = 0;
    step(1);
    start = 1'b0;
    chk({tag, " wait state"}, int'(state), 1);
    chk({tag, " react cleared"}, int'(react_ms), 0);
    chk({tag, " winner cleared"}, int'(winner), 0);
    chk({tag, " foul cleared"}, int'(foul), 0);
    chk({tag, " done low"}, int'(done), 0);
  endtask

  task automatic wait_led(input string tag, input int t);
    int k;
    k = 0;
    while (!led && k < 100) begin
      step(1);
      k++;
    end
    chk({tag, " led delay"}, since, 4 * t + 1);
    chk({tag, " armed state"}, int'(state), 2);
    delays.push_back(since);
  endtask

  typedef struct {
    int           idle;
    logic         clr;
    logic         st;
    logic [N-1:0] sp;
    int           e_state;
    logic         e_led;
    logic         e_done;
    logic [N-1:0] e_foul;
    int           e_react;
    int           e_winner;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int distinct;

    vecs[0] = '{2, 1'b1, 1'b1, 3'b000, 0, 1'b0, 1'b0, 3'b000, 0, 0};
    vecs[1] = '{1, 1'b0, 1'b1, 3'b000, 1, 1'b0, 1'b0, 3'b000, 0, 0};
    vecs[2] = '{7, 1'b0, 1'b0, 3'b001, 4, 1'b0, 1'b1, 3'b001, 0, 0};
    vecs[3] = '{0, 1'b0, 1'b0, 3'b000, 4, 1'b0, 1'b0, 3'b001, 0, 0};
    vecs[4] = '{1, 1'b0, 1'b0, 3'b100, 4, 1'b0, 1'b0, 3'b001, 0, 0};
    vecs[5] = '{1, 1'b0, 1'b1, 3'b000, 1, 1'b0, 1'b0, 3'b000, 0, 0};
    vecs[6] = '{0, 1'b0, 1'b0, 3'b110, 4, 1'b0, 1'b1, 3'b110, 0, 0};
    vecs[7] = '{3, 1'b0, 1'b1, 3'b000, 1, 1'b0, 1'b0, 3'b000, 0, 0};
    vecs[8] = '{1, 1'b0, 1'b1, 3'b000, 1, 1'b0, 1'b0, 3'b000, 0, 0};
    vecs[9] = '{0, 1'b1, 1'b0, 3'b000, 0, 1'b0, 1'b0, 3'b000, 0, 0};

    clear = 1'b1;
    start = 1'b0;
    stop  = '0;
    repeat (3) @(negedge clk_50M);
    chk("reset state", int'(state), 0);
    chk("reset led", int'(led), 0);
    chk("reset done", int'(done), 0);
    clear = 1'b0;

    for (int i = 0; i < 10; i++) begin
      repeat (vecs[i].idle) @(negedge clk_50M);
      clear = vecs[i].clr;
      start = vecs[i].st;
      stop  = vecs[i].sp;
      @(negedge clk_50M);
      clear = 1'b0;
      start = 1'b0;
      stop  = '0;
      chk($sformatf("vec%0d state", i), int'(state), vecs[i].e_state);
      chk($sformatf("vec%0d led", i), int'(led), int'(vecs[i].e_led));
      chk($sformatf("vec%0d done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("vec%0d foul", i), int'(foul), int'(vecs[i].e_foul));
      chk($sformatf("vec%0d react", i), int'(react_ms), vecs[i].e_react);
      chk($sformatf("vec%0d winner", i), int'(winner), vecs[i].e_winner);
    end

    // Round 1: start ignored in WAIT and ARMED, stop[1] after 7 ticks, late stop ignored.
    begin_round("r1", t);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("r1 start in wait", int'(state), 1);
    wait_led("r1", t);
    step(10);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("r1 start in armed", int'(state), 2);
    chk("r1 react mid", int'(react_ms), 2);
    chk("r1 led mid", int'(led), 1);
    step(18);
    stop = 3'b010;
    step(1);
    stop = '0;
    chk("r1 done state", int'(state), 3);
    chk("r1 winner", int'(winner), 1);
    chk("r1 react", int'(react_ms), 7);
    chk("r1 led off", int'(led), 0);
    chk("r1 done pulse", int'(done), 1);
    step(1);
    chk("r1 done drop", int'(done), 0);
    stop = 3'b001;
    step(1);
    stop = '0;
    chk("r1 late stop state", int'(state), 3);
    chk("r1 late stop winner", int'(winner), 1);
    chk("r1 late stop react", int'(react_ms), 7);
    chk("r1 late stop done", int'(done), 0);

    // Round 2: started from DONE, no stop -> timeout.
    begin_round("r2", t);
    wait_led("r2", t);
    step(83);
    chk("r2 pre-timeout state", int'(state), 2);
    chk("r2 pre-timeout react", int'(react_ms), TMO);
    chk("r2 pre-timeout led", int'(led), 1);
    step(1);
    chk("r2 timeout state", int'(state), 5);
    chk("r2 timeout react", int'(react_ms), TMO);
    chk("r2 timeout led", int'(led), 0);
    chk("r2 timeout done", int'(done), 1);
    step(1);
    chk("r2 done drop", int'(done), 0);
    chk("r2 hold state", int'(state), 5);

    // Round 3: simultaneous stop[0] and stop[2].
    begin_round("r3", t);
    wait_led("r3", t);
    step(5);
    stop = 3'b101;
    step(1);
    stop = '0;
    chk("r3 state", int'(state), 3);
    chk("r3 winner", int'(winner), 0);
    chk("r3 react", int'(react_ms), 1);
    chk("r3 done", int'(done), 1);

    // Round 4: stop on the very cycle the delay expires.
    begin_round("r4", t);
    step(4 * t - 1);
    chk("r4 pre-expiry state", int'(state), 1);
    chk("r4 pre-expiry led", int'(led), 0);
    stop = 3'b010;
    step(1);
    stop = '0;
    chk("r4 foul state", int'(state), 4);
    chk("r4 foul vec", int'(foul), 2);
    chk("r4 foul led", int'(led), 0);
    chk("r4 foul done", int'(done), 1);

    // Round 5: stop on the timeout tick wins.
    begin_round("r5", t);
    wait_led("r5", t);
    step(83);
    stop = 3'b100;
    step(1);
    stop = '0;
    chk("r5 state", int'(state), 3);
    chk("r5 react", int'(react_ms), TMO);
    chk("r5 winner", int'(winner), 2);
    chk("r5 done", int'(done), 1);

    // Round 6: clear mid-ARMED with stops held through release.
    begin_round("r6", t);
    wait_led("r6", t);
    step(10);
    clear = 1'b1;
    stop  = 3'b111;
    step(1);
    chk("r6 clear state", int'(state), 0);
    chk("r6 clear led", int'(led), 0);
    chk("r6 clear react", int'(react_ms), 0);
    chk("r6 clear done", int'(done), 0);
    clear = 1'b0;
    step(1);
    chk("r6 held stop idle", int'(state), 0);
    begin_round("r7", t);
    wait_led("r7", t);
    step(10);
    chk("r7 held stop armed", int'(state), 2);
    stop = '0;
    step(1);
    stop = 3'b001;
    step(1);
    stop = '0;
    chk("r7 state", int'(state), 3);
    chk("r7 winner", int'(winner), 0);
    chk("r7 react tick edge", int'(react_ms), 2);

    distinct = 0;
    foreach (delays[i]) begin
      if (delays[i] != delays[0]) distinct = 1;
    end
    chk("delays differ across rounds", distinct, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
